cross_bar_arbiter: RTL and testbench
====================================

CROSS_BAR_ARBITER -- requirements
Module: cross_bar_arbiter

Interface
REQ-001 Parameter MASTER_N, default 4, number of masters competing for one slave port.
REQ-002 Parameter MASTER_W, default $clog2(MASTER_N), width of the master index.
REQ-003 Parameter TIMEOUT, default 256, maximum cycles a grant may wait for slave_ack.
REQ-004 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port master_req, input, MASTER_N, per-master request already decoded for this slave (req AND address-select match).
REQ-007 Port slave_ack, input, 1, acknowledge from the slave port, already synchronised to clk.
REQ-008 Port grant, output, MASTER_N, one-hot grant steering this slave's mux; all-zero when idle.
REQ-009 Port grant_idx, output, MASTER_W, binary index of the granted master; valid only while busy = 1.
REQ-010 Port busy, output, 1, high while a grant is held (GRANT or RELEASE state).
REQ-011 Port timeout_err, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 FSM states: IDLE, GRANT, RELEASE; the encoding is registered.
REQ-013 IDLE: if any master_req bit is set in cycle N, the arbiter shall select a winner and assert grant/grant_idx/busy from cycle N+1 (1-cycle latency), entering GRANT.
REQ-014 Selection: round-robin; search starts at index (ptr+1) mod MASTER_N and wraps; first set bit wins.
REQ-015 ptr shall update to the winner index only when a transaction ends (RELEASE exit, abort, or timeout), never on grant.
REQ-016 GRANT: on slave_ack = 1, go to RELEASE; grant stays unchanged.
REQ-017 GRANT: if master_req[grant_idx] drops before slave_ack, treat it as an abort: go to IDLE next cycle, grant = 0, ptr = grant_idx, no error.
REQ-018 GRANT: a saturating wait counter counts cycles in GRANT; reaching TIMEOUT shall pulse timeout_err for 1 cycle, go to IDLE, set ptr = grant_idx.
REQ-019 RELEASE: hold grant until master_req[grant_idx] = 0, then go to IDLE the next cycle with grant = 0 and ptr updated; this covers the master holding req for 2+ clocks after ack.
REQ-020 The earliest re-grant after IDLE entry is the following cycle; grant shall never switch directly from one master to another without at least one all-zero cycle.
REQ-021 Requests from non-granted masters while busy = 1 shall be ignored and not latched; they are re-evaluated in IDLE.
REQ-022 slave_ack in IDLE or RELEASE shall be ignored.
REQ-023 Simultaneous slave_ack and requester drop in GRANT: slave_ack takes priority, so go to RELEASE; RELEASE then exits on the next cycle.
REQ-024 Simultaneous slave_ack and timeout terminal count: slave_ack takes priority and no timeout_err is raised.
REQ-025 grant shall be exactly one-hot or zero in every cycle, and grant[grant_idx] = busy.

Reset
REQ-026 While reset = 1 at a clk edge: state = IDLE, grant = 0, grant_idx = 0, busy = 0, timeout_err = 0, wait counter = 0, ptr = MASTER_N-1, so master 0 has first priority.
REQ-027 Reset asserted mid-transaction shall drop grant in the cycle after the reset edge, with no timeout_err.

Structure
REQ-028 MASTER_N, SLAVE_N, MASTER_W, SLAVE_W, ADDR_W, DATA_W, addr_t and data_t shall come from cross_bar_pkg; the FSM state enum shall also be placed in cross_bar_pkg.
REQ-029 The wrap-around priority search shall be a combinational sub-module cross_bar_rr_pick (inputs req and ptr; outputs onehot, idx and any).
REQ-030 The top level shall instantiate one cross_bar_arbiter per slave (SLAVE_N instances).

Verification
REQ-031 Reset released, master_req = 4'b0100 -> grant = 4'b0100 and grant_idx = 2 one cycle later; slave_ack -> RELEASE; req drop -> grant = 0 the next cycle.
REQ-032 After reset, master_req = 4'b1111 held, ack each transaction -> grant order 0, 1, 2, 3, 0, with an all-zero grant cycle between each.
REQ-033 TIMEOUT = 8, master_req = 4'b0001, no ack -> timeout_err pulses 1 cycle after 8 GRANT cycles and grant = 0; the next request from master 1 wins over master 0.
REQ-034 Grant to master 3, master 3 drops req before ack -> grant = 0 next cycle, timeout_err = 0; with 4'b1001 pending, master 0 wins next.
REQ-035 In GRANT, assert slave_ack and drop req in the same cycle -> RELEASE for one cycle, then IDLE.
REQ-036 Assert reset during RELEASE with master_req = 4'b0010 held -> grant = 0 after the reset edge; after release, master 1 is re-granted with priority starting from 0.

Source files
------------

// File: rtl/cross_bar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_pkg
// Description : Shared crossbar sizing, bus types and the arbiter FSM state
//               encoding used by every per-slave arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 2;
    localparam int MASTER_W = $clog2(MASTER_N);
    localparam int SLAVE_W  = $clog2(SLAVE_N);
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Arbiter FSM encoding (held in a register, never decoded from outputs).
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_GRANT   = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;

endpackage : cross_bar_pkg
`default_nettype wire

// File: rtl/cross_bar.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar
// Description : Arbitration layer of the crossbar: one cross_bar_arbiter per
//               slave port, each fed with requests already address-decoded
//               for that slave.
// Ports       : clk, reset  - clock and synchronous active-high reset
//               master_req  - per-slave decoded request vectors
//               slave_ack   - per-slave acknowledge
//               grant, grant_idx, busy, timeout_err - per-slave arbiter outputs
// Revision    : 1.0 - initial release
// ============================================================================
module cross_bar #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int SLAVE_N  = cross_bar_pkg::SLAVE_N,
    parameter int MASTER_W = $clog2(MASTER_N),
    parameter int TIMEOUT  = 256
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [SLAVE_N-1:0][MASTER_N-1:0]   master_req,
    input  logic [SLAVE_N-1:0]                 slave_ack,
    output logic [SLAVE_N-1:0][MASTER_N-1:0]   grant,
    output logic [SLAVE_N-1:0][MASTER_W-1:0]   grant_idx,
    output logic [SLAVE_N-1:0]                 busy,
    output logic [SLAVE_N-1:0]                 timeout_err
);

    generate
        for (genvar s = 0; s < SLAVE_N; s++) begin : g_slave
            cross_bar_arbiter #(
                .MASTER_N (MASTER_N),
                .MASTER_W (MASTER_W),
                .TIMEOUT  (TIMEOUT)
            ) u_arb (
                .clk         (clk),
                .reset       (reset),
                .master_req  (master_req[s]),
                .slave_ack   (slave_ack[s]),
                .grant       (grant[s]),
                .grant_idx   (grant_idx[s]),
                .busy        (busy[s]),
                .timeout_err (timeout_err[s])
            );
        end
    endgenerate

endmodule : cross_bar
`default_nettype wire

// File: rtl/cross_bar_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_rr_pick
// Description : Combinational round-robin picker. Searches req starting at
//               (ptr+1) mod MASTER_N, wrapping, and returns the first set bit.
// Ports       : req    - request vector
//               ptr    - index of the last master served
//               onehot - one-hot winner (zero when no request)
//               idx    - binary winner index (zero when no request)
//               any    - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module cross_bar_rr_pick #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int MASTER_W = $clog2(MASTER_N)
) (
    input  logic [MASTER_N-1:0] req,
    input  logic [MASTER_W-1:0] ptr,
    output logic [MASTER_N-1:0] onehot,
    output logic [MASTER_W-1:0] idx,
    output logic                any
);

    int                w_pos;
    logic [MASTER_W-1:0] w_sel;

    // Offsets 1..MASTER_N visit every master exactly once, the last master
    // served (offset MASTER_N) being considered last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_pos  = 0;
        w_sel  = '0;
        for (int k = 1; k <= MASTER_N; k++) begin
            w_pos = (int'(ptr) + k) % MASTER_N;
            w_sel = MASTER_W'(w_pos);
            if (!any && req[w_sel]) begin
                any           = 1'b1;
                idx           = w_sel;
                onehot[w_sel] = 1'b1;
            end
        end
    end

endmodule : cross_bar_rr_pick
`default_nettype wire

// File: rtl/cross_bar_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_arbiter
// Description : Round-robin arbiter for one crossbar slave port. Grants one
//               master at a time, holds the grant through ack until the
//               master drops its request, and revokes a stalled grant after
//               TIMEOUT cycles without ack.
// Ports       : clk         - clock, rising edge
//               reset       - synchronous active-high reset
//               master_req  - decoded per-master requests for this slave
//               slave_ack   - slave acknowledge (synchronous to clk)
//               grant       - one-hot grant, zero when idle
//               grant_idx   - binary grant index, valid while busy
//               busy        - grant held (GRANT or RELEASE)
//               timeout_err - one-cycle pulse when a grant times out
// Revision    : 1.0 - initial release
// ============================================================================
module cross_bar_arbiter #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int MASTER_W = $clog2(MASTER_N),
    parameter int TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MASTER_N-1:0] master_req,
    input  logic                slave_ack,
    output logic [MASTER_N-1:0] grant,
    output logic [MASTER_W-1:0] grant_idx,
    output logic                busy,
    output logic                timeout_err
);

    import cross_bar_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              r_state,  w_state_nxt;
    logic [MASTER_N-1:0] r_grant,  w_grant_nxt;
    logic [MASTER_W-1:0] r_idx,    w_idx_nxt;
    logic [MASTER_W-1:0] r_ptr,    w_ptr_nxt;
    logic [WAIT_W-1:0]   r_wait,   w_wait_nxt;
    logic                r_terr,   w_terr_nxt;

    logic [MASTER_N-1:0] w_pick_onehot;
    logic [MASTER_W-1:0] w_pick_idx;
    logic                w_pick_any;

    cross_bar_rr_pick #(
        .MASTER_N (MASTER_N),
        .MASTER_W (MASTER_W)
    ) u_pick (
        .req    (master_req),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= MASTER_W'(MASTER_N - 1);  // master 0 searched first
            r_wait  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wait  <= w_wait_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    // r_wait holds the number of GRANT cycles already completed, so the
    // terminal count is seen in the TIMEOUT-th GRANT cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_wait_nxt  = r_wait;
        w_terr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wait_nxt = '0;
                if (w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick_onehot;
                    w_idx_nxt   = w_pick_idx;
                end
            end
            ST_GRANT: begin
                // ack outranks both an abort and the timeout.
                if (slave_ack) begin
                    w_state_nxt = ST_RELEASE;
                end else if (!master_req[r_idx]) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_idx;
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_idx;
                    w_terr_nxt  = 1'b1;
                end else if (r_wait != WAIT_W'(TIMEOUT)) begin
                    w_wait_nxt  = r_wait + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!master_req[r_idx]) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_idx;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign busy        = (r_state == ST_GRANT) || (r_state == ST_RELEASE);
    assign timeout_err = r_terr;

endmodule : cross_bar_arbiter
`default_nettype wire

// File: tb/tb_cross_bar_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cross_bar_arbiter
// Description : Directed self-checking bench for cross_bar_arbiter
//               (MASTER_N = 4, TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cross_bar_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] master_req;
    logic       slave_ack;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    cross_bar_arbiter #(
        .MASTER_N (4),
        .MASTER_W (2),
        .TIMEOUT  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .master_req  (master_req),
        .slave_ack   (slave_ack),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(grant) || (grant[grant_idx] !== busy)) begin
                errors++;
                $display("FAIL invariant: grant=%b idx=%0d busy=%b", grant, grant_idx, busy);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; master_req = 4'b0000; slave_ack = 1'b0;
        step(); step();
        checks++;
        if ({grant, grant_idx, busy, timeout_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got grant=%b idx=%0d busy=%b terr=%b, want all zero",
                     grant, grant_idx, busy, timeout_err);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        master_req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b idx=%0d busy=%b, want 0100/2/1", grant, grant_idx, busy);
        end
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got grant=%b busy=%b, want 0100/1", grant, busy);
        end
        step();  // req still held after ack: grant must persist
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL single_hold: got grant=%b, want 0100", grant);
        end
        master_req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: got grant=%b busy=%b, want 0000/0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1;
        step();
        reset = 1'b0;
        master_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (grant !== exp_order[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, want %b", i, grant, exp_order[i]);
            end
            slave_ack = 1'b1;
            step();
            slave_ack = 1'b0;
            master_req = 4'b1111 & ~exp_order[i];
            step();
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap[%0d]: got %b, want 0000", i, grant);
            end
            master_req = 4'b1111;
        end
        master_req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        master_req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL to_wait[%0d]: got grant=%b terr=%b, want 0001/0", c, grant, timeout_err);
            end
        end
        step();
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_fire: got grant=%b terr=%b busy=%b, want 0000/1/0", grant, timeout_err, busy);
        end
        master_req = 4'b0011;
        step();
        checks++;
        if (timeout_err !== 1'b0 || grant !== 4'b0010 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL to_next: got grant=%b idx=%0d terr=%b, want 0010/1/0", grant, grant_idx, timeout_err);
        end
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        master_req = 4'b0000;
        step();
    endtask

    task automatic test_abort();
        master_req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL abort_grant: got grant=%b idx=%0d, want 1000/3", grant, grant_idx);
        end
        master_req = 4'b1001;  // master 0 request must be ignored while busy
        step();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL abort_ignore: got grant=%b, want 1000", grant);
        end
        master_req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: got grant=%b terr=%b busy=%b, want 0000/0/0", grant, timeout_err, busy);
        end
        master_req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL abort_next: got grant=%b idx=%0d, want 0001/0", grant, grant_idx);
        end
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        master_req = 4'b0000;
        step();
    endtask

    task automatic test_ack_drop();
        master_req = 4'b0100;
        step();
        slave_ack = 1'b1;
        master_req = 4'b0000;
        step();
        slave_ack = 1'b0;
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ackdrop_rel: got grant=%b busy=%b, want 0100/1", grant, busy);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ackdrop_idle: got grant=%b busy=%b, want 0000/0", grant, busy);
        end
    endtask

    task automatic test_ack_at_timeout();
        master_req = 4'b0001;
        for (int c = 1; c <= 8; c++) step();
        slave_ack = 1'b1;  // coincides with terminal count
        step();
        slave_ack = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL ack_vs_to: got grant=%b busy=%b terr=%b, want 0001/1/0", grant, busy, timeout_err);
        end
        master_req = 4'b0000;
        step();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_vs_to_end: got busy=%b terr=%b, want 0/0", busy, timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        master_req = 4'b0010;
        step();
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: got grant=%b idx=%0d busy=%b terr=%b, want 0000/0/0/0",
                     grant, grant_idx, busy, timeout_err);
        end
        reset = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL rst_regrant: got grant=%b idx=%0d, want 0010/1", grant, grant_idx);
        end
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        master_req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_abort();
        test_ack_drop();
        test_ack_at_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cross_bar_arbiter
`default_nettype wire
